// File: rtl/immediate_fetcher_if.sv
// Command, result and prefetch-FIFO signals of the immediate fetcher.
// slave = fetcher side; master = requester plus FIFO side.
interface immediate_fetcher_if #(
   parameter int OUT_WIDTH = 32
);
   logic                 start;
   logic [1:0]           size;
   logic                 sign_extend;
   logic                 flush;
   logic                 busy;
   logic                 complete;
   logic [OUT_WIDTH-1:0] immediate;
   logic                 fifo_rd_en;
   logic [7:0]           fifo_rd_data;
   logic                 fifo_empty;

   modport master (
      output start, size, sign_extend, flush, fifo_rd_data, fifo_empty,
      input  busy, complete, immediate, fifo_rd_en
   );

   modport slave (
      input  start, size, sign_extend, flush, fifo_rd_data, fifo_empty,
      output busy, complete, immediate, fifo_rd_en
   );
endinterface

// File: rtl/immediate_fetcher.sv
// Pops a 1/2/4-byte little-endian immediate from the prefetch FIFO and extends it to OUT_WIDTH.
// Define IMMEDIATE_FETCHER_FAR_PTR_EN for 4-byte far-pointer fetches (size 2/3); OUT_WIDTH must then be 32.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | popping and capturing bytes until n have arrived
// DONE  | one cycle, complete pulses, immediate valid
module immediate_fetcher #(
   parameter int OUT_WIDTH = 32
) (
   input logic                clk,
   input logic                reset,
   immediate_fetcher_if.slave bus
);

`ifdef IMMEDIATE_FETCHER_FAR_PTR_EN
   localparam int NB = 4;
   localparam int CW = 3;
`else
   localparam int NB = 2;
   localparam int CW = 2;
`endif
   localparam int BW = NB * 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] issued_q;
   logic [CW-1:0] received_q;
   logic [CW-1:0] n_q;
   logic [CW-1:0] n_req;
   logic [BW-1:0] byte_buf_q;
   logic          sign_q;
   logic          rd_pend_q;
   logic          start_ok;
   logic          rd_en;
   logic          complete_c;
   logic          last_byte;
   logic [31:0]   ext32;

   always_comb begin
`ifdef IMMEDIATE_FETCHER_FAR_PTR_EN
      case (bus.size)
         2'd0:    n_req = 3'd1;
         2'd1:    n_req = 3'd2;
         default: n_req = 3'd4;
      endcase
`else
      n_req = (bus.size == 2'd0) ? 2'd1 : 2'd2;
`endif
   end

   // rd_pend_q marks that fifo_rd_data holds the byte popped last cycle
   assign last_byte = rd_pend_q && (received_q == (n_q - CW'(1)));

   always_comb begin
      state_d    = state_q;
      start_ok   = 1'b0;
      rd_en      = 1'b0;
      complete_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               start_ok = 1'b1;
               state_d  = FETCH;
            end
         end
         FETCH: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               rd_en = !bus.fifo_empty && (issued_q < n_q);
               if (last_byte) state_d = DONE;
            end
         end
         DONE: begin
            complete_c = !bus.flush;
            state_d    = IDLE;
            if (bus.start && !bus.flush) begin
               start_ok = 1'b1;
               state_d  = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         issued_q   <= '0;
         received_q <= '0;
         n_q        <= '0;
         sign_q     <= 1'b0;
         byte_buf_q <= '0;
         rd_pend_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= rd_en;
         if (start_ok) begin
            issued_q   <= '0;
            received_q <= '0;
            byte_buf_q <= '0;
            n_q        <= n_req;
            sign_q     <= bus.sign_extend;
         end else if (state_q == FETCH && !bus.flush) begin
            if (rd_en) issued_q <= issued_q + CW'(1);
            if (rd_pend_q) begin
               for (int i = 0; i < NB; i++) begin
                  if (received_q == CW'(i)) byte_buf_q[i*8 +: 8] <= bus.fifo_rd_data;
               end
               received_q <= received_q + CW'(1);
            end
         end
      end
   end

   always_comb begin
      ext32 = '0;
      case (n_q)
         CW'(1):  ext32 = {{24{sign_q & byte_buf_q[7]}}, byte_buf_q[7:0]};
         CW'(2):  ext32 = {{16{sign_q & byte_buf_q[15]}}, byte_buf_q[15:0]};
`ifdef IMMEDIATE_FETCHER_FAR_PTR_EN
         CW'(4):  ext32 = byte_buf_q;
`endif
         default: ext32 = '0;
      endcase
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.complete   = complete_c;
   assign bus.fifo_rd_en = rd_en;
   assign bus.immediate  = ext32[OUT_WIDTH-1:0];

endmodule
